// File: rtl/regfile_wb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_pkg
//   Shared sizing constants and small helpers for the write-back register file.
//   Provides register count, address/data widths, the pending-counter width,
//   and the canonical zero word / "no register" address.
// -----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int REG_NUM = 32;  // architectural registers, x0 hardwired zero
    localparam int ADDR_W  = 5;   // register address width
    localparam int DATA_W  = 32;  // register data width
    localparam int CNT_W   = 2;   // in-flight writes per register: EX, MEM, WB

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [ADDR_W-1:0] NOP_REG_ADDR = '0;

    // True for any register that can actually hold a value (everything but x0).
    function automatic logic is_real_reg(input logic [ADDR_W-1:0] addr);
        return addr != NOP_REG_ADDR;
    endfunction

endpackage

// File: rtl/regfile_pend_cnt.sv
// -----------------------------------------------------------------------------
// regfile_pend_cnt
//   One saturating up/down counter tracking how many writes to a single
//   register are in flight between ID->EX issue and write-back commit.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high; clears the count
//   inc       in   an issue targets this register (already qualified)
//   dec       in   a commit targets this register (already qualified)
//   cnt       out  current count (registered)
//   overflow  out  combinational: an issue arrived while the count is full
// -----------------------------------------------------------------------------
module regfile_pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Simultaneous inc and dec cancel. Increment saturates at the maximum and
    // flags overflow; decrement at zero simply holds (a commit of a write that
    // was issued before a reset lands here).
    always_comb begin
        cnt_next = cnt_reg;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (cnt_reg == CNT_MAX) begin
                overflow = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
//   Write-back end of the pipeline: integer register file written from the
//   MEM/WB interface, two combinational ID read ports with same-cycle WB bypass,
//   and a per-register pending-write scoreboard used by ID to request stalls.
//
// Ports
//   clk, rst                     clock / asynchronous active-high reset
//   rdy                          global ready; low freezes all state
//   wb_stall                     WB held this cycle; its write is not committed
//   wb_wd, wb_wreg, wb_wdata     write-back destination, enable, data
//   issue_valid, issue_wd,
//   issue_wreg                   instruction leaving ID into EX this cycle
//   regN_read, regN_addr         read port N enable / address (N = 1, 2)
//   regN_data                    read port N data (combinational, bypassed)
//   regN_pending                 read port N source has uncommitted writes
//   cnt_overflow                 sticky: issue hit a full pending counter
// -----------------------------------------------------------------------------
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int P_REG_NUM = REG_NUM,
    parameter int P_ADDR_W  = ADDR_W,
    parameter int P_DATA_W  = DATA_W,
    parameter int P_CNT_W   = CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                wb_stall,
    input  logic [P_ADDR_W-1:0] wb_wd,
    input  logic                wb_wreg,
    input  logic [P_DATA_W-1:0] wb_wdata,
    input  logic                issue_valid,
    input  logic [P_ADDR_W-1:0] issue_wd,
    input  logic                issue_wreg,
    input  logic                reg1_read,
    input  logic [P_ADDR_W-1:0] reg1_addr,
    output logic [P_DATA_W-1:0] reg1_data,
    output logic                reg1_pending,
    input  logic                reg2_read,
    input  logic [P_ADDR_W-1:0] reg2_addr,
    output logic [P_DATA_W-1:0] reg2_data,
    output logic                reg2_pending,
    output logic                cnt_overflow
);

    logic                commit;
    logic                issue;
    logic [P_DATA_W-1:0] regs_reg [P_REG_NUM];
    logic [P_CNT_W-1:0]  cnt_arr  [P_REG_NUM];
    logic [P_REG_NUM-1:0] ovf_vec;
    logic                cnt_overflow_reg;

    // Both qualifiers fold in rdy; wb_stall only gates the commit side.
    assign commit = rdy & ~wb_stall & wb_wreg & is_real_reg(wb_wd);
    assign issue  = rdy & issue_valid & issue_wreg & is_real_reg(issue_wd);

    // Storage. The asynchronous clear of every entry rules out a block RAM,
    // which the combinational read ports would not allow anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P_REG_NUM; i++) begin
                regs_reg[i] <= ZERO_WORD;
            end
        end else if (commit) begin
            regs_reg[wb_wd] <= wb_wdata;
        end
    end

    // Pending-write counters. x0 never gets one: it can never be written.
    assign cnt_arr[0] = '0;
    assign ovf_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < P_REG_NUM; gi++) begin : g_cnt
            regfile_pend_cnt #(
                .CNT_W(P_CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .inc      (issue  && (issue_wd == P_ADDR_W'(gi))),
                .dec      (commit && (wb_wd    == P_ADDR_W'(gi))),
                .cnt      (cnt_arr[gi]),
                .overflow (ovf_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_overflow_reg <= 1'b0;
        end else if (|ovf_vec) begin
            cnt_overflow_reg <= 1'b1;
        end
    end

    assign cnt_overflow = cnt_overflow_reg;

    // Read ports, index 0 = port 1, index 1 = port 2.
    logic [1:0]          rd_en;
    logic [P_ADDR_W-1:0] rd_addr [2];
    logic [P_DATA_W-1:0] rd_data [2];
    logic [1:0]          rd_pend;

    assign rd_en      = {reg2_read, reg1_read};
    assign rd_addr[0] = reg1_addr;
    assign rd_addr[1] = reg2_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic               active;
            logic               hit;
            logic [P_CNT_W-1:0] cnt_sel;

            assign active  = rd_en[gi] && is_real_reg(rd_addr[gi]);
            assign hit     = commit && (wb_wd == rd_addr[gi]);
            assign cnt_sel = cnt_arr[rd_addr[gi]];

            assign rd_data[gi] = !active ? ZERO_WORD :
                                 hit     ? wb_wdata  : regs_reg[rd_addr[gi]];

            // Outstanding writes other than the one being bypassed right now.
            // A commit against a zero count (pre-reset write) leaves nothing
            // outstanding rather than wrapping the difference.
            assign rd_pend[gi] = active && (cnt_sel != '0) &&
                                 !(hit && (cnt_sel == P_CNT_W'(1)));
        end
    endgenerate

    assign reg1_data    = rd_data[0];
    assign reg2_data    = rd_data[1];
    assign reg1_pending = rd_pend[0];
    assign reg2_pending = rd_pend[1];

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              wb_stall;
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_wd;
    logic              issue_wreg;
    logic              reg1_read;
    logic [ADDR_W-1:0] reg1_addr;
    logic [DATA_W-1:0] reg1_data;
    logic              reg1_pending;
    logic              reg2_read;
    logic [ADDR_W-1:0] reg2_addr;
    logic [DATA_W-1:0] reg2_data;
    logic              reg2_pending;
    logic              cnt_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              pend;
        logic              ovf;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .wb_stall     (wb_stall),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .issue_valid  (issue_valid),
        .issue_wd     (issue_wd),
        .issue_wreg   (issue_wreg),
        .reg1_read    (reg1_read),
        .reg1_addr    (reg1_addr),
        .reg1_data    (reg1_data),
        .reg1_pending (reg1_pending),
        .reg2_read    (reg2_read),
        .reg2_addr    (reg2_addr),
        .reg2_data    (reg2_data),
        .reg2_pending (reg2_pending),
        .cnt_overflow (cnt_overflow)
    );

    task automatic idle();
        rdy         = 1'b1;
        wb_stall    = 1'b0;
        wb_wd       = '0;
        wb_wreg     = 1'b0;
        wb_wdata    = '0;
        issue_valid = 1'b0;
        issue_wd    = '0;
        issue_wreg  = 1'b0;
    endtask

    // Advance one clock; inputs change 1 ns after the edge, outputs are
    // sampled 1 ns later still, well away from the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_issue(input logic [ADDR_W-1:0] rd);
        issue_valid = 1'b1;
        issue_wd    = rd;
        issue_wreg  = 1'b1;
    endtask

    task automatic do_commit(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        wb_wreg  = 1'b1;
        wb_wd    = rd;
        wb_wdata = d;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        idle();
        reg1_read = 1'b1;
        reg2_read = 1'b1;
        for (int a = 1; a < REG_NUM; a++) begin
            reg1_addr = ADDR_W'(a);
            reg2_addr = ADDR_W'(REG_NUM - a);
            exp_q.push_back('{data: '0, pend: 1'b0, ovf: 1'b0});
            exp_q.push_back('{data: '0, pend: 1'b0, ovf: 1'b0});
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (reg1_data !== e.data || reg1_pending !== e.pend || cnt_overflow !== e.ovf) begin
                tests_failed++;
                $display("FAIL reset p1 x%0d: got data=%h pend=%b ovf=%b, want data=%h pend=%b ovf=%b",
                         a, reg1_data, reg1_pending, cnt_overflow, e.data, e.pend, e.ovf);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (reg2_data !== e.data || reg2_pending !== e.pend) begin
                tests_failed++;
                $display("FAIL reset p2 x%0d: got data=%h pend=%b, want data=%h pend=%b",
                         REG_NUM - a, reg2_data, reg2_pending, e.data, e.pend);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        exp_t e;
        reg1_addr = 5'd5;
        reg2_addr = 5'd5;
        for (int s = 0; s < 3; s++) begin
            if (s == 0) do_commit(5'd5, 32'hDEADBEEF);
            exp_q.push_back('{data: 32'hDEADBEEF, pend: 1'b0, ovf: 1'b0});
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (reg1_data !== e.data || reg2_data !== e.data) begin
                tests_failed++;
                $display("FAIL bypass step %0d: got p1=%h p2=%h, want %h",
                         s, reg1_data, reg2_data, e.data);
            end
            tick();
        end
    endtask

    task automatic test_x0_write();
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            reg1_read = 1'b1;
            reg1_addr = (s == 1) ? 5'd1 : 5'd0;
            reg2_addr = 5'd5;
            if (s == 0) do_commit(5'd0, 32'h0000_1234);
            if (s == 2) begin
                reg1_read = 1'b0;
                reg1_addr = 5'd5;
            end
            exp_q.push_back('{data: '0, pend: 1'b0, ovf: 1'b0});
            exp_q.push_back('{data: 32'hDEADBEEF, pend: 1'b0, ovf: 1'b0});
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (reg1_data !== e.data || reg1_pending !== e.pend) begin
                tests_failed++;
                $display("FAIL x0_write p1 step %0d: got data=%h pend=%b, want data=%h pend=%b",
                         s, reg1_data, reg1_pending, e.data, e.pend);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (reg2_data !== e.data) begin
                tests_failed++;
                $display("FAIL x0_write p2 step %0d: got data=%h, want data=%h",
                         s, reg2_data, e.data);
            end
            tick();
        end
        reg1_read = 1'b1;
    endtask

    task automatic test_pending();
        exp_t e;
        logic [DATA_W-1:0] d;
        logic              p;
        reg1_addr = 5'd7;
        for (int s = 0; s < 6; s++) begin
            case (s)
                0, 2: do_issue(5'd7);
                3:    do_commit(5'd7, 32'd1);
                4:    do_commit(5'd7, 32'd2);
                default: ;
            endcase
            d = (s == 3) ? 32'd1 : (s >= 4) ? 32'd2 : 32'd0;
            p = (s >= 1 && s <= 3);
            exp_q.push_back('{data: d, pend: p, ovf: 1'b0});
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (reg1_data !== e.data || reg1_pending !== e.pend || cnt_overflow !== e.ovf) begin
                tests_failed++;
                $display("FAIL pending step %0d: got data=%h pend=%b ovf=%b, want data=%h pend=%b ovf=%b",
                         s, reg1_data, reg1_pending, cnt_overflow, e.data, e.pend, e.ovf);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [DATA_W-1:0] d;
        logic              p;
        reg1_addr = 5'd9;
        for (int s = 0; s < 16; s++) begin
            case (s)
                0, 6, 12: do_issue(5'd9);
                1, 2, 3:  begin do_commit(5'd9, 32'hA5); wb_stall = 1'b1; end
                4:        do_commit(5'd9, 32'hA5);
                7, 8, 9:  begin do_commit(5'd9, 32'h5A); rdy = 1'b0; end
                10:       do_commit(5'd9, 32'h5A);
                14:       do_commit(5'd9, 32'h77);
                default: ;
            endcase
            d = (s < 4) ? 32'h0 : (s < 10) ? 32'hA5 : (s < 14) ? 32'h5A : 32'h77;
            p = (s >= 1 && s <= 3) || (s >= 7 && s <= 9) || (s == 13);
            exp_q.push_back('{data: d, pend: p, ovf: 1'b0});
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (reg1_data !== e.data || reg1_pending !== e.pend || cnt_overflow !== e.ovf) begin
                tests_failed++;
                $display("FAIL stall step %0d: got data=%h pend=%b ovf=%b, want data=%h pend=%b ovf=%b",
                         s, reg1_data, reg1_pending, cnt_overflow, e.data, e.pend, e.ovf);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        logic [DATA_W-1:0] d;
        reg1_addr = 5'd3;
        reg2_addr = 5'd5;
        for (int s = 0; s < 8; s++) begin
            if (s < 4) do_issue(5'd3);
            if (s == 6) do_commit(5'd3, 32'h33);
            d = (s >= 6) ? 32'h33 : 32'h0;
            exp_q.push_back('{data: d, pend: (s >= 1), ovf: (s >= 4)});
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (reg1_data !== e.data || reg1_pending !== e.pend || cnt_overflow !== e.ovf) begin
                tests_failed++;
                $display("FAIL overflow step %0d: got data=%h pend=%b ovf=%b, want data=%h pend=%b ovf=%b",
                         s, reg1_data, reg1_pending, cnt_overflow, e.data, e.pend, e.ovf);
            end
            tick();
        end
        // Asynchronous reset between clock edges must act at once.
        #2;
        rst = 1'b1;
        exp_q.push_back('{data: '0, pend: 1'b0, ovf: 1'b0});
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (reg1_data !== e.data || reg1_pending !== e.pend || cnt_overflow !== e.ovf || reg2_data !== e.data) begin
            tests_failed++;
            $display("FAIL async_rst: got x3=%h pend=%b ovf=%b x5=%h, want data=%h pend=%b ovf=%b",
                     reg1_data, reg1_pending, cnt_overflow, reg2_data, e.data, e.pend, e.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        // Counter starts fresh after reset: a single issue shows pending, no overflow.
        do_issue(5'd3);
        tick();
        exp_q.push_back('{data: '0, pend: 1'b1, ovf: 1'b0});
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (reg1_data !== e.data || reg1_pending !== e.pend || cnt_overflow !== e.ovf) begin
            tests_failed++;
            $display("FAIL post_rst_issue: got data=%h pend=%b ovf=%b, want data=%h pend=%b ovf=%b",
                     reg1_data, reg1_pending, cnt_overflow, e.data, e.pend, e.ovf);
        end
    endtask

    initial begin
        rst       = 1'b1;
        reg1_read = 1'b0;
        reg1_addr = '0;
        reg2_read = 1'b0;
        reg2_addr = '0;
        idle();
        test_reset();
        test_bypass();
        test_x0_write();
        test_pending();
        test_stall();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
